// File: rtl/alu_chain_seq_pkg.sv
// Shared definitions for the byte-serial chained adder: controller state
// encodings and the opcodes driven onto the external 8-bit ALU.
package alu_chain_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StCin  = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic ALU_OP_IDLE = 1'b0;
  localparam logic ALU_OP_ADD  = 1'b1;

endpackage

// File: rtl/alu_chain_seq.sv
// Wide adder built by chaining an external carry-in-less 8-bit ALU, least
// significant byte first. Each byte takes two ALU passes: A+B, then the
// partial sum plus the incoming carry.
// Optional feature: define ALU_CHAIN_SKIP_EN to skip the carry pass for
// bytes whose incoming carry is zero.
module alu_chain_seq
  import alu_chain_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] sum,
  output logic                carry_out,
  output logic                overflow,
  output logic                alu_op,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  input  logic [7:0]          alu_result,
  input  logic                alu_cf,
  input  logic                alu_ovf
);

  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NBYTES - 1);

  state_e                     state_q, state_d;
  logic [NBYTES-1:0][7:0]     a_q, a_d;
  logic [NBYTES-1:0][7:0]     b_q, b_d;
  logic [NBYTES-1:0][7:0]     sum_q, sum_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [7:0]                 tmp_q, tmp_d;
  logic                       cf1_q, cf1_d;
  logic                       carry_q, carry_d;
  logic                       carry_out_q, carry_out_d;
  logic                       overflow_q, overflow_d;
  logic                       skip_cin;
  logic                       last_byte;
  logic                       ovf_final;

  // The ALU's own overflow flag only covers one byte, so it is not used.
  logic unused_alu_ovf;
  assign unused_alu_ovf = alu_ovf;

`ifdef ALU_CHAIN_SKIP_EN
  assign skip_cin = ~carry_q;
`else
  assign skip_cin = 1'b0;
`endif

  assign last_byte = (idx_q == LastIdx);
  // Signed overflow judged on the top result byte as it is being written.
  assign ovf_final = (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) &&
                     (alu_result[7] != a_q[NBYTES-1][7]);

  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

  // Next-state, datapath updates and ALU drive.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    tmp_d       = tmp_q;
    cf1_d       = cf1_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    alu_op      = ALU_OP_IDLE;
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    busy        = 1'b1;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = StAdd;
        end
      end

      StAdd: begin
        alu_op = ALU_OP_ADD;
        alu_a  = a_q[idx_q];
        alu_b  = b_q[idx_q];
        if (skip_cin) begin
          // No incoming carry: the A+B pass is already the final byte.
          sum_d[idx_q] = alu_result;
          carry_d      = alu_cf;
          if (last_byte) begin
            carry_out_d = alu_cf;
            overflow_d  = ovf_final;
            state_d     = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          tmp_d   = alu_result;
          cf1_d   = alu_cf;
          state_d = StCin;
        end
      end

      StCin: begin
        alu_op       = ALU_OP_ADD;
        alu_a        = tmp_q;
        alu_b        = {7'b0, carry_q};
        sum_d[idx_q] = alu_result;
        // At most one of the two passes can carry, so OR merges them.
        carry_d      = cf1_q | alu_cf;
        if (last_byte) begin
          carry_out_d = cf1_q | alu_cf;
          overflow_d  = ovf_final;
          state_d     = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StAdd;
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      tmp_q       <= '0;
      cf1_q       <= 1'b0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      tmp_q       <= tmp_d;
      cf1_q       <= cf1_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_alu_chain_seq.sv
// Scoreboard bench for alu_chain_seq with a behavioural 8-bit ALU on the
// alu_* ports. Expected results come from full-width integer arithmetic.
module tb_alu_chain_seq;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] sum;
  logic         alu_op;
  logic [7:0]   alu_a, alu_b, alu_result;
  logic         alu_cf, alu_ovf;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    longint       lat;
    longint       acc;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  alu_chain_seq #(.NBYTES(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .carry_out  (carry_out),
    .overflow   (overflow),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_cf     (alu_cf),
    .alu_ovf    (alu_ovf)
  );

  // Team ALU: plain 8-bit add, no carry-in.
  assign {alu_cf, alu_result} = alu_op ? ({1'b0, alu_a} + {1'b0, alu_b}) : 9'd0;
  assign alu_ovf = alu_op & (alu_a[7] == alu_b[7]) & (alu_result[7] != alu_a[7]);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edges from accept to done: fixed two passes per byte, or with skipping
  // one pass per byte plus one more for each byte that receives a carry.
  function automatic longint model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    longint n;
    logic [63:0] mask, part;
`ifdef ALU_CHAIN_SKIP_EN
    n = NB;
    for (int i = 1; i < NB; i++) begin
      mask = (64'd1 << (8 * i)) - 64'd1;
      part = ((64'(a) & mask) + (64'(b) & mask)) >> (8 * i);
      if (part != 64'd0) n++;
    end
`else
    n = 2 * NB;
    mask = 64'(a);
    part = 64'(b);
`endif
    return n;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending request");
      end else begin
        e = sb.pop_front();
        chk("sum", 64'(sum), 64'(e.sum));
        chk("carry_out", 64'(carry_out), 64'(e.cout));
        chk("overflow", 64'(overflow), 64'(e.ovf));
        chk("latency", 64'(cyc - e.acc), 64'(e.lat));
        chk("busy_in_done", 64'(busy), 64'd1);
        chk("alu_op_in_done", 64'(alu_op), 64'd0);
      end
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 8 * NB && busy; k++) @(negedge clk);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
    end
  endtask

  // Issue one add, pulse a stray start mid-run and during DONE, scramble
  // the operand inputs after acceptance, then confirm the result holds.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [W:0]  full;
    int          k;
    wait_idle();
    full   = {1'b0, a} + {1'b0, b};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    e.lat  = model_lat(a, b);
    e.acc  = cyc + 1;
    sb.push_back(e);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    for (k = 0; k < 4 * NB + 4; k++) begin
      if (done) break;
      start = (k == 2);
      @(negedge clk);
      start = 1'b0;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 expected 1 within %0d cycles", 4 * NB + 4);
    end else begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("busy_after_done", 64'(busy), 64'd0);
      chk("sum_hold", 64'(sum), 64'(e.sum));
      chk("alu_op_idle", 64'(alu_op), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish by 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_carry_out", 64'(carry_out), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'h0000_0005, 32'h0000_002B);
    issue(32'h0000_00FF, 32'h0000_0001);
    issue(32'hFFFF_FFFF, 32'h0000_0001);
    issue(32'h8000_0000, 32'h8000_0000);
    issue(32'h7FFF_FFFF, 32'h0000_0001);

    // Abort a run with a mid-run reset; no result is expected from it.
    wait_idle();
    op_a  = 32'hFFFF_FFFF;
    op_b  = 32'h0101_0101;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    op_a  = 32'h1234_5678;
    chk("busy_mid_run", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_alu_op", 64'(alu_op), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(32'h0000_0005, 32'h0000_002B);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 4 == 1) rb = ~ra + W'($urandom_range(0, 1));
      if (n % 4 == 2) ra = {ra[W-1:8], 8'hFF};
      issue(ra, rb);
    end

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
